// File: rtl/video_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_pkg
// Description : Standard raster mode constants and axis region decode helper.
// Revision    : 1.0
// ============================================================================
package video_timing_pkg;

  typedef enum logic [1:0] {
    REGION_FP     = 2'd0,
    REGION_SYNC   = 2'd1,
    REGION_BP     = 2'd2,
    REGION_ACTIVE = 2'd3
  } region_t;

  // 640x480 @ 60 Hz (25.175 MHz)
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;
  localparam int VGA_H_ACTIVE  = 640;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;
  localparam int VGA_V_ACTIVE  = 480;
  localparam bit VGA_H_POL     = 1'b0;
  localparam bit VGA_V_POL     = 1'b0;

  // 800x600 @ 60 Hz (40 MHz)
  localparam int SVGA_H_FP     = 40;
  localparam int SVGA_H_SYNC   = 128;
  localparam int SVGA_H_BP     = 88;
  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_V_FP     = 1;
  localparam int SVGA_V_SYNC   = 4;
  localparam int SVGA_V_BP     = 23;
  localparam int SVGA_V_ACTIVE = 600;
  localparam bit SVGA_H_POL    = 1'b1;
  localparam bit SVGA_V_POL    = 1'b1;

  // 1024x768 @ 60 Hz (65 MHz)
  localparam int XGA_H_FP      = 24;
  localparam int XGA_H_SYNC    = 136;
  localparam int XGA_H_BP      = 160;
  localparam int XGA_H_ACTIVE  = 1024;
  localparam int XGA_V_FP      = 3;
  localparam int XGA_V_SYNC    = 6;
  localparam int XGA_V_BP      = 29;
  localparam int XGA_V_ACTIVE  = 768;
  localparam bit XGA_H_POL     = 1'b0;
  localparam bit XGA_V_POL     = 1'b0;

  // Regions are laid out front porch, sync, back porch, active from count 0.
  function automatic region_t region_of(input int c, input int fp, input int sync, input int bp);
    region_t r;
    if (c < fp)
      r = REGION_FP;
    else if (c < fp + sync)
      r = REGION_SYNC;
    else if (c < fp + sync + bp)
      r = REGION_BP;
    else
      r = REGION_ACTIVE;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/video_axis_timer.sv
`default_nettype none
// ============================================================================
// Module      : video_axis_timer
// Description : One raster axis: wrapping position counter with region decode.
// Revision    : 1.0
// ============================================================================
module video_axis_timer
  import video_timing_pkg::*;
#(
  parameter int FP     = 40,
  parameter int SYNC   = 128,
  parameter int BP     = 88,
  parameter int ACTIVE = 800,
  parameter int W      = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic         advance,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         in_sync,
  output logic         in_active,
  output logic [W-1:0] pos
);

  localparam int           TOTAL     = FP + SYNC + BP + ACTIVE;
  localparam logic [W-1:0] LAST      = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_START = W'(FP + SYNC + BP);

  region_t region;

  assign region    = region_of(int'(count), FP, SYNC, BP);
  assign in_sync   = (region == REGION_SYNC);
  assign in_active = (region == REGION_ACTIVE);
  assign pos       = in_active ? (count - ACT_START) : '0;

  // wrap is independent of ce so the next axis can chain on it directly.
  assign wrap = advance && (count == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (ce && advance) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen
// Description : Parametrised raster timing generator with pixel clock-enable.
// Revision    : 1.0
// ============================================================================
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_FP     = SVGA_H_FP,
  parameter int H_SYNC   = SVGA_H_SYNC,
  parameter int H_BP     = SVGA_H_BP,
  parameter int H_ACTIVE = SVGA_H_ACTIVE,
  parameter int V_FP     = SVGA_V_FP,
  parameter int V_SYNC   = SVGA_V_SYNC,
  parameter int V_BP     = SVGA_V_BP,
  parameter int V_ACTIVE = SVGA_V_ACTIVE,
  parameter bit H_POL    = SVGA_H_POL,
  parameter bit V_POL    = SVGA_V_POL,
  parameter int XW       = 11,
  parameter int YW       = 10
) (
  input  logic          clk_video,
  input  logic          rst_video_n,
  input  logic          pix_ce,
  output logic          hsync,
  output logic          vsync,
  output logic          hblank,
  output logic          vblank,
  output logic          de,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam logic [XW-1:0] H_ACT_START = XW'(H_FP + H_SYNC + H_BP);
  localparam logic [YW-1:0] V_ACT_START = YW'(V_FP + V_SYNC + V_BP);

  logic [XW-1:0] h_count;
  logic [XW-1:0] h_pos;
  logic          h_wrap;
  logic          h_in_sync;
  logic          h_in_active;

  logic [YW-1:0] v_count;
  logic [YW-1:0] v_pos;
  logic          v_wrap;
  logic          v_in_sync;
  logic          v_in_active;

  logic          line_first;
  logic          frame_first;
  logic          unused_v_wrap;

  video_axis_timer #(
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .ACTIVE (H_ACTIVE),
    .W      (XW)
  ) u_h_timer (
    .clk       (clk_video),
    .rst_n     (rst_video_n),
    .ce        (pix_ce),
    .advance   (1'b1),
    .count     (h_count),
    .wrap      (h_wrap),
    .in_sync   (h_in_sync),
    .in_active (h_in_active),
    .pos       (h_pos)
  );

  // The line counter steps in the same clock as the column wrap; no derived clock.
  video_axis_timer #(
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .ACTIVE (V_ACTIVE),
    .W      (YW)
  ) u_v_timer (
    .clk       (clk_video),
    .rst_n     (rst_video_n),
    .ce        (pix_ce),
    .advance   (h_wrap),
    .count     (v_count),
    .wrap      (v_wrap),
    .in_sync   (v_in_sync),
    .in_active (v_in_active),
    .pos       (v_pos)
  );

  assign unused_v_wrap = v_wrap;

  assign line_first  = (h_count == H_ACT_START) && v_in_active;
  assign frame_first = line_first && (v_count == V_ACT_START);

  // Outputs sample the counters on each ce, so they lag the counters by one ce and
  // hold (strobes included) through ce=0 cycles.
  always_ff @(posedge clk_video) begin
    if (!rst_video_n) begin
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      hblank      <= 1'b1;
      vblank      <= 1'b1;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_ce) begin
      hsync       <= (h_in_sync == H_POL);
      vsync       <= (v_in_sync == V_POL);
      hblank      <= ~h_in_active;
      vblank      <= ~v_in_active;
      de          <= h_in_active && v_in_active;
      x           <= h_pos;
      y           <= v_pos;
      line_start  <= line_first;
      frame_start <= frame_first;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_timing_gen
// Description : Self-checking bench for video_timing_gen in a 10x7 raster mode.
// Revision    : 1.0
// ============================================================================
module tb_video_timing_gen;

  localparam int HT = 10;
  localparam int VT = 7;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic pix_ce = 1'b0;

  logic       hs1, vs1, hb1, vb1, de1, ls1, fs1;
  logic [3:0] x1;
  logic [2:0] y1;
  logic       hs0, vs0, hb0, vb0, de0, ls0, fs0;
  logic [3:0] x0;
  logic [2:0] y0;

  video_timing_gen #(
    .H_FP(2), .H_SYNC(3), .H_BP(1), .H_ACTIVE(4),
    .V_FP(1), .V_SYNC(2), .V_BP(1), .V_ACTIVE(3),
    .H_POL(1'b1), .V_POL(1'b1), .XW(4), .YW(3)
  ) u_p1 (
    .clk_video(clk), .rst_video_n(rst_n), .pix_ce(pix_ce),
    .hsync(hs1), .vsync(vs1), .hblank(hb1), .vblank(vb1), .de(de1),
    .x(x1), .y(y1), .line_start(ls1), .frame_start(fs1)
  );

  video_timing_gen #(
    .H_FP(2), .H_SYNC(3), .H_BP(1), .H_ACTIVE(4),
    .V_FP(1), .V_SYNC(2), .V_BP(1), .V_ACTIVE(3),
    .H_POL(1'b0), .V_POL(1'b0), .XW(4), .YW(3)
  ) u_p0 (
    .clk_video(clk), .rst_video_n(rst_n), .pix_ce(pix_ce),
    .hsync(hs0), .vsync(vs0), .hblank(hb0), .vblank(vb0), .de(de0),
    .x(x0), .y(y0), .line_start(ls0), .frame_start(fs0)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int clk_n  = 0;

  // Reference model: raster position of the next ce, and the expected registered outputs.
  int   mcol = 0, mline = 0;
  logic e_hs = 1'b0, e_vs = 1'b0, e_hb = 1'b1, e_vb = 1'b1, e_de = 1'b0, e_ls = 1'b0, e_fs = 1'b0;
  int   e_x = 0, e_y = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (clk %0d)", tag, got, exp, clk_n);
    end
  endtask

  function automatic logic [13:0] pk(input logic hs, input logic vs, input logic hb, input logic vb,
                                     input logic d, input logic [3:0] px, input logic [2:0] py,
                                     input logic ls, input logic fs);
    return {hs, vs, hb, vb, d, px, py, ls, fs};
  endfunction

  task automatic step(input logic ce, input logic rn);
    logic was_wrap;
    logic [3:0] ex;
    logic [2:0] ey;
    was_wrap = 1'b0;
    pix_ce = ce;
    rst_n  = rn;
    @(posedge clk);
    clk_n++;
    if (!rn) begin
      mcol = 0; mline = 0;
      e_hs = 0; e_vs = 0; e_hb = 1; e_vb = 1; e_de = 0; e_x = 0; e_y = 0; e_ls = 0; e_fs = 0;
    end else if (ce) begin
      e_hs = (mcol >= 2) && (mcol < 5);
      e_vs = (mline >= 1) && (mline < 3);
      e_hb = !(mcol >= 6);
      e_vb = !(mline >= 4);
      e_de = !e_hb && !e_vb;
      e_x  = e_hb ? 0 : mcol - 6;
      e_y  = e_vb ? 0 : mline - 4;
      e_ls = (mcol == 6) && !e_vb;
      e_fs = (mcol == 6) && (mline == 4);
      was_wrap = (mcol == HT - 1) && (mline == VT - 1);
      mcol = (mcol + 1) % HT;
      if (mcol == 0) mline = (mline + 1) % VT;
    end
    #1;
    ex = 4'(e_x);
    ey = 3'(e_y);
    check("outs_pol1", 32'(pk(hs1, vs1, hb1, vb1, de1, x1, y1, ls1, fs1)),
          32'(pk(e_hs, e_vs, e_hb, e_vb, e_de, ex, ey, e_ls, e_fs)));
    check("outs_pol0", 32'(pk(hs0, vs0, hb0, vb0, de0, x0, y0, ls0, fs0)),
          32'(pk(!e_hs, !e_vs, e_hb, e_vb, e_de, ex, ey, e_ls, e_fs)));
    if (was_wrap)
      check("wrap_to_00", 32'({u_p1.h_count, u_p1.v_count}), 32'd0);
  endtask

  initial begin
    int   de_n, fs_n, ls_n, vs_n, hs_w, hs_first, hs_rise2, vs_first, fs_idx;
    int   fs_prev_rise, fs_run, ls_run, ce_cnt;
    logic hs_prev, fs_prev, ls_prev, found;

    // Reset held 3 clocks with ce active.
    repeat (3) step(1'b1, 1'b0);
    check("rst_state_p1", 32'(pk(hs1, vs1, hb1, vb1, de1, x1, y1, ls1, fs1)), 32'(14'b00110_0000_000_00));
    check("rst_state_p0", 32'({hs0, vs0}), 32'b11);

    // One full frame at full rate.
    de_n = 0; fs_n = 0; ls_n = 0; vs_n = 0; hs_w = 0;
    hs_first = -1; hs_rise2 = -1; vs_first = -1; fs_idx = -1; hs_prev = 1'b0;
    for (int i = 1; i <= HT * VT; i++) begin
      step(1'b1, 1'b1);
      de_n += int'(de1);
      ls_n += int'(ls1);
      vs_n += int'(vs1);
      if (i <= HT) hs_w += int'(hs1);
      if (vs1 && vs_first < 0) vs_first = i;
      if (hs1 && !hs_prev) begin
        if (hs_first < 0) hs_first = i;
        else if (hs_rise2 < 0) hs_rise2 = i;
      end
      if (fs1) begin
        fs_n++;
        fs_idx = i;
        check("fs_coincident", 32'({de1, ls1, x1, y1}), 32'({1'b1, 1'b1, 4'd0, 3'd0}));
      end
      hs_prev = hs1;
    end
    check("de_per_frame", de_n, 12);
    check("fs_per_frame", fs_n, 1);
    check("ls_per_frame", ls_n, 3);
    check("vs_width", vs_n, 20);
    check("vs_first_ce", vs_first, 11);
    check("hs_first_ce", hs_first, 3);
    check("hs_width", hs_w, 3);
    check("hs_period", hs_rise2 - hs_first, 10);
    check("fs_ce_index", fs_idx, 47);

    // ce pattern 1,0,0: frame period and strobe stretch.
    fs_prev_rise = -1; fs_run = 0; ls_run = 0; fs_prev = 1'b0; ls_prev = 1'b0;
    for (int i = 0; i < 700; i++) begin
      step(i % 3 == 0, 1'b1);
      if (fs1 && !fs_prev) begin
        if (fs_prev_rise >= 0) check("fs_period_ce3", clk_n - fs_prev_rise, 210);
        fs_prev_rise = clk_n;
      end
      if (fs1) fs_run++;
      else if (fs_prev) begin check("fs_hold", fs_run, 3); fs_run = 0; end
      if (ls1) ls_run++;
      else if (ls_prev) begin check("ls_hold", ls_run, 3); ls_run = 0; end
      fs_prev = fs1;
      ls_prev = ls1;
    end

    // Reset in the middle of an active line.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (mcol == 7 && mline == 5) found = 1'b1;
      else step(1'b1, 1'b1);
    end
    check("reach_mid_frame", 32'(found), 32'd1);
    step(1'b1, 1'b0);
    check("mid_rst_state", 32'(pk(hs1, vs1, hb1, vb1, de1, x1, y1, ls1, fs1)), 32'(14'b00110_0000_000_00));
    ce_cnt = 0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1'b1, 1'b1);
      ce_cnt++;
      if (fs1) found = 1'b1;
    end
    check("restart_fs_ce", ce_cnt, 47);

    // Random ce and sporadic resets against the model.
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 299) != 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
